// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register built as a two-entry skid buffer (main + skid).
// Define EX_MEM_BRANCH_EN to carry a branch target and zero flag through the stage.
module ex_mem_stage #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         flush,
    input  logic [W-1:0] PC_E4,
    input  logic [W-1:0] ALU_E,
    input  logic [W-1:0] B_E,
`ifdef EX_MEM_BRANCH_EN
    input  logic [W-1:0] IMM_E,
    input  logic         ZERO_E,
    output logic [W-1:0] BTARGET_M,
    output logic         ZERO_M,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] PC_M4,
    output logic [W-1:0] ALUOUT_M,
    output logic [W-1:0] WD_M
);

    logic         r_mainValid;
    logic         r_skidValid;
    logic [W-1:0] r_mainPc;
    logic [W-1:0] r_mainAlu;
    logic [W-1:0] r_mainWd;
    logic [W-1:0] r_skidPc;
    logic [W-1:0] r_skidAlu;
    logic [W-1:0] r_skidWd;

    logic w_accept;
    logic w_handoff;
    logic w_mainFree;
    logic w_mainLoad;
    logic w_skidLoad;

    // in_ready comes straight from the skid valid flop, so out_ready never reaches it.
    assign in_ready   = ~r_skidValid;
    assign w_accept   = in_valid & ~r_skidValid;
    assign w_handoff  = r_mainValid & out_ready;
    assign w_mainFree = ~r_mainValid | w_handoff;
    assign w_mainLoad = ~flush & w_mainFree & (r_skidValid | w_accept);
    assign w_skidLoad = ~flush & ~w_mainFree & w_accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mainValid <= 1'b0;
            r_skidValid <= 1'b0;
        end else if (flush) begin
            r_mainValid <= 1'b0;
            r_skidValid <= 1'b0;
        end else if (w_mainFree) begin
            r_mainValid <= r_skidValid | w_accept;
            r_skidValid <= 1'b0;
        end else if (w_accept) begin
            r_skidValid <= 1'b1;
        end
    end

    // A waiting skid entry always takes priority into main, keeping FIFO order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mainPc  <= '0;
            r_mainAlu <= '0;
            r_mainWd  <= '0;
            r_skidPc  <= '0;
            r_skidAlu <= '0;
            r_skidWd  <= '0;
        end else begin
            if (w_skidLoad) begin
                r_skidPc  <= PC_E4;
                r_skidAlu <= ALU_E;
                r_skidWd  <= B_E;
            end
            if (w_mainLoad) begin
                r_mainPc  <= r_skidValid ? r_skidPc  : PC_E4;
                r_mainAlu <= r_skidValid ? r_skidAlu : ALU_E;
                r_mainWd  <= r_skidValid ? r_skidWd  : B_E;
            end
        end
    end

    assign out_valid = r_mainValid;
    assign PC_M4     = r_mainPc;
    assign ALUOUT_M  = r_mainAlu;
    assign WD_M      = r_mainWd;

`ifdef EX_MEM_BRANCH_EN
    logic [W-1:0] r_mainBt;
    logic [W-1:0] r_skidBt;
    logic         r_mainZero;
    logic         r_skidZero;
    logic [W-1:0] w_btarget;

    // Target is formed at accept time and wraps modulo 2^W.
    assign w_btarget = PC_E4 + (IMM_E << 2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mainBt   <= '0;
            r_skidBt   <= '0;
            r_mainZero <= 1'b0;
            r_skidZero <= 1'b0;
        end else begin
            if (w_skidLoad) begin
                r_skidBt   <= w_btarget;
                r_skidZero <= ZERO_E;
            end
            if (w_mainLoad) begin
                r_mainBt   <= r_skidValid ? r_skidBt   : w_btarget;
                r_mainZero <= r_skidValid ? r_skidZero : ZERO_E;
            end
        end
    end

    assign BTARGET_M = r_mainBt;
    assign ZERO_M    = r_mainZero;
`endif

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL provide parameter: W, 32, datapath width of all data ports.
REQ-002 SHALL use one clock and an asynchronous, active-low reset.
REQ-003 SHALL provide these ports, one per line (name, direction, width, meaning):
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  EX stage presents a result
- in_ready  out  1  stage can accept a result
- flush  in  1  discard all held entries
- PC_E4  in  W  EX-stage PC+4
- ALU_E  in  W  EX-stage ALU result
- B_E  in  W  EX-stage store data
- IMM_E  in  W  EX-stage immediate; present only with the macro
- ZERO_E  in  1  ALU zero flag; present only with the macro
- out_valid  out  1  MEM-side entry valid
- out_ready  in  1  MEM stage consumes entry
- PC_M4  out  W  registered PC+4
- ALUOUT_M  out  W  registered ALU result
- WD_M  out  W  registered store data
- BTARGET_M  out  W  branch target; present only with the macro
- ZERO_M  out  1  registered zero flag; present only with the macro

Function
REQ-004 SHALL implement a two-entry skid buffer: a main register driving the outputs, plus one skid register.
REQ-005 SHALL accept an input on a rising edge where in_valid=1 and in_ready=1.
REQ-006 SHALL drive in_ready = NOT skid_valid, decoded from a register only, with no combinational path from out_ready.
REQ-007 SHALL hand off an output on a rising edge where out_valid=1 and out_ready=1.
REQ-008 SHALL make an accepted entry visible on the outputs one cycle after acceptance when the main register is empty or being handed off (latency 1).
REQ-009 SHALL place an accepted entry in the skid register when the main register is valid and not being handed off in the same cycle.
REQ-010 SHALL move the skid entry into the main register on a handoff; a simultaneous accept is then not possible, because in_ready=0.
REQ-011 SHALL hold all outputs stable while out_valid=1 and out_ready=0.
REQ-012 SHALL preserve strict FIFO order; no entry is lost or duplicated.
REQ-013 SHALL, when flush=1 at an edge, clear both valid bits; flush wins over a simultaneous accept or handoff, and in_ready=1 in the following cycle.
REQ-014 SHALL leave data registers unchanged on flush; only the valid bits clear.
REQ-015 SHALL keep out_valid=0 whenever the main register is empty, regardless of out_ready.

Reset
REQ-016 SHALL, while rst_n=0 (independent of clk), force out_valid=0, skid_valid=0, in_ready=1, and all data outputs to 0.
REQ-017 SHALL discard any entry in flight when reset asserts mid-operation; first accept is possible on the first edge after deassertion.

Configuration
REQ-018 SHALL use the macro EX_MEM_BRANCH_EN to compile the branch feature in or out.
REQ-019 SHALL, with EX_MEM_BRANCH_EN defined, add IMM_E, ZERO_E, BTARGET_M and ZERO_M, with BTARGET_M = PC_E4 + (IMM_E << 2) computed at accept, carried through the skid register, modulo 2^W.
REQ-020 SHALL, without EX_MEM_BRANCH_EN, omit those four ports and all of their storage.

Verification
REQ-021 SHALL cover: reset asserted with in_valid=1 -> out_valid=0, in_ready=1, all outputs 0.
REQ-022 SHALL cover: accept PC_E4=0x04, ALU_E=0x10, B_E=0xAA, out_ready=1 -> next cycle out_valid=1, ALUOUT_M=0x10, WD_M=0xAA.
REQ-023 SHALL cover: out_ready=0, two consecutive accepts A=0x1 then B=0x2 -> in_ready=0 after B; out_ready=1 -> outputs A then B on consecutive cycles.
REQ-024 SHALL cover: main and skid full, flush=1 together with in_valid=1 -> next cycle out_valid=0, in_ready=1, nothing accepted.
REQ-025 SHALL cover: EX_MEM_BRANCH_EN defined, PC_E4=0xFFFFFFFC, IMM_E=0x2 -> BTARGET_M=0x00000004 (wrap-around).
REQ-026 SHALL cover: rst_n pulsed low mid-stream with skid full -> both valids clear immediately; an accept on the first post-reset edge appears one cycle later.
